// File: rtl/alu_operand_sequencer_if.sv
// Nibble command stream and result handshake for the ALU operand sequencer.
// master = producer/consumer side, slave = sequencer side.
interface alu_operand_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        nib_in;
    logic              nib_valid;
    logic              nib_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output nib_in, nib_valid, res_ready,
        input  nib_ready, res_data, res_valid
    );

    modport slave (
        input  nib_in, nib_valid, res_ready,
        output nib_ready, res_data, res_valid
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Assembles ALU operands/opcode from a nibble stream and returns the result.
// Optional inter-nibble timeout enabled by defining SEQ_TIMEOUT_EN.
module alu_operand_sequencer #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_operand_sequencer_if.slave bus,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [3:0]             alu_op,
    input  logic [DATA_W-1:0]      alu_result,
    output logic                   busy,
    output logic                   err
);
    localparam int NIB   = DATA_W / 4;
    localparam int LAST  = 2 * NIB;
    localparam int IDX_W = $clog2(LAST + 1);

    if (DATA_W < 4 || DATA_W % 4 != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("alu_operand_sequencer: bad parameters");
    end

    typedef enum logic [1:0] {LOAD, EXEC, HOLD} state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              last_nib;
    logic              expire;
    logic [DATA_W-1:0] a_nx;
    logic [DATA_W-1:0] b_nx;
    logic [3:0]        op_nx;
    logic [DATA_W-1:0] res_q;
    logic              res_v_q;

    assign bus.nib_ready = (state == LOAD);
    assign accept        = bus.nib_valid && (state == LOAD);
    assign last_nib      = (idx == IDX_W'(LAST));
    assign busy          = (state != LOAD) || (idx != '0);
    assign bus.res_data  = res_q;
    assign bus.res_valid = res_v_q;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (accept && last_nib) state_nx = EXEC;
            EXEC:    state_nx = HOLD;
            HOLD:    if (bus.res_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Each accepted nibble lands directly in its operand/opcode slot
    always_comb begin
        a_nx  = alu_a;
        b_nx  = alu_b;
        op_nx = alu_op;
        for (int i = 0; i < NIB; i++) begin
            if (accept && idx == IDX_W'(i))
                a_nx[4*i +: 4] = bus.nib_in;
            if (accept && idx == IDX_W'(NIB + i))
                b_nx[4*i +: 4] = bus.nib_in;
        end
        if (accept && last_nib) op_nx = bus.nib_in;
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr;
    logic             stall;
    logic             err_q;

    assign stall  = (state == LOAD) && (idx != '0) && !accept;
    assign expire = stall && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
            if (stall && !expire) tmr <= tmr + 1'b1;
            else                  tmr <= '0;
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            res_q   <= '0;
            res_v_q <= 1'b0;
        end else begin
            if (expire) begin
                idx    <= '0;
                alu_a  <= '0;
                alu_b  <= '0;
                alu_op <= '0;
            end else begin
                alu_a  <= a_nx;
                alu_b  <= b_nx;
                alu_op <= op_nx;
                if (accept) idx <= last_nib ? '0 : idx + 1'b1;
            end
            if (state == EXEC) begin
                res_q   <= alu_result;
                res_v_q <= 1'b1;
            end else if (state == HOLD && bus.res_ready) begin
                res_v_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed self-checking bench for alu_operand_sequencer (ALU model: a + b).
// Define SEQ_TIMEOUT_EN on both DUT and bench to exercise the timeout path.
module tb_alu_operand_sequencer;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              err;

    int tests    = 0;
    int fails    = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer_if #(.DATA_W(DATA_W)) bus ();

    alu_operand_sequencer #(
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .busy(busy),
        .err(err)
    );

    assign alu_result = alu_a + alu_b;

    always @(negedge clk) if (err === 1'b1) err_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_nib(input logic [3:0] n);
        int w = 0;
        bus.nib_in    = n;
        bus.nib_valid = 1'b1;
        while (bus.nib_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            tests++;
            fails++;
            $display("FAIL nib_accept: nib_ready never rose");
        end
        @(negedge clk);
        bus.nib_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input int maxgap);
        logic [19:0] cmd;
        cmd = {op, b, a};
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
                if (maxgap > 0) bus.res_ready = 1'($urandom % 2);
                @(negedge clk);
            end
            send_nib(cmd[4*k +: 4]);
        end
    endtask

    task automatic wait_res();
        int w = 0;
        while (bus.res_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            tests++;
            fails++;
            $display("FAIL res_wait: res_valid never rose");
        end
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({alu_a, alu_b, alu_op, bus.res_data, bus.res_valid, busy, err} !== '0) begin
            fails++;
            $display("FAIL reset_state: got a=%h b=%h op=%h rd=%h rv=%b busy=%b err=%b want all 0",
                     alu_a, alu_b, alu_op, bus.res_data, bus.res_valid, busy, err);
        end
        tests++;
        if (bus.nib_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", bus.nib_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_cmd(8'h35, 8'h12, 4'h0, 0);
        tests++;
        if (bus.res_valid !== 1'b0 || alu_a !== 8'h35 || alu_b !== 8'h12
            || alu_op !== 4'h0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_exec: rv=%b a=%h b=%h op=%h busy=%b want 0 35 12 0 1",
                     bus.res_valid, alu_a, alu_b, alu_op, busy);
        end
        @(negedge clk);
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h47) begin
            fails++;
            $display("FAIL basic_result: rv=%b rd=%h want 1 47", bus.res_valid, bus.res_data);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h47) begin
            fails++;
            $display("FAIL basic_held: rv=%b rd=%h want 1 47", bus.res_valid, bus.res_data);
        end
        tests++;
        if (bus.nib_ready !== 1'b0) begin
            fails++;
            $display("FAIL hs_ready: nib_ready=%b want 0", bus.nib_ready);
        end
        bus.nib_in    = 4'h9;
        bus.nib_valid = 1'b1;
        handshake();
        bus.nib_valid = 1'b0;
        tests++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_release: rv=%b busy=%b want 0 0", bus.res_valid, busy);
        end
    endtask

    task automatic test_hold_wrap();
        int bad = 0;
        send_cmd(8'hFF, 8'h02, 4'h0, 0);
        @(negedge clk);
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h01) begin
            fails++;
            $display("FAIL wrap_result: rv=%b rd=%h want 1 01", bus.res_valid, bus.res_data);
        end
        for (int i = 0; i < 10; i++) begin
            bus.nib_in    = 4'hA;
            bus.nib_valid = 1'(i % 2);
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h01 || bus.nib_ready !== 1'b0)
                bad++;
        end
        bus.nib_valid = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
        end
        tests++;
        if (alu_a !== 8'hFF || alu_b !== 8'h02 || alu_op !== 4'h0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_ignore: a=%h b=%h op=%h busy=%b want ff 02 0 1",
                     alu_a, alu_b, alu_op, busy);
        end
        handshake();
        tests++;
        if (bus.res_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_release: rv=%b want 0", bus.res_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] exp;
        for (int n = 0; n < 50; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            op  = 4'($urandom);
            exp = a + b;
            send_cmd(a, b, op, 3);
            wait_res();
            tests++;
            if (bus.res_data !== exp) begin
                fails++;
                $display("FAIL rand_result[%0d]: got %h want %h", n, bus.res_data, exp);
            end
            tests++;
            if (alu_a !== a || alu_b !== b || alu_op !== op) begin
                fails++;
                $display("FAIL rand_operands[%0d]: got %h %h %h want %h %h %h",
                         n, alu_a, alu_b, alu_op, a, b, op);
            end
            bus.res_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
            bus.res_ready = 1'($urandom % 2);
        end
        bus.res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_nib(4'hC);
        send_nib(4'h9);
        send_nib(4'hD);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({alu_a, alu_b, alu_op, bus.res_data, bus.res_valid, busy, err} !== '0) begin
            fails++;
            $display("FAIL mid_reset: a=%h b=%h op=%h rd=%h rv=%b busy=%b want all 0",
                     alu_a, alu_b, alu_op, bus.res_data, bus.res_valid, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        send_cmd(8'h21, 8'h13, 4'h2, 0);
        wait_res();
        tests++;
        if (bus.res_data !== 8'h34 || alu_b !== 8'h13 || alu_op !== 4'h2) begin
            fails++;
            $display("FAIL mid_fresh: rd=%h b=%h op=%h want 34 13 2",
                     bus.res_data, alu_b, alu_op);
        end
        handshake();
    endtask

    task automatic test_reset_hold();
        int bad = 0;
        send_cmd(8'h10, 8'h20, 4'h0, 0);
        wait_res();
        tests++;
        if (bus.res_data !== 8'h30) begin
            fails++;
            $display("FAIL hold_pre: rd=%h want 30", bus.res_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00) begin
            fails++;
            $display("FAIL hold_reset: rv=%b rd=%h want 0 00", bus.res_valid, bus.res_data);
        end
        bus.res_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) bad++;
        end
        bus.res_ready = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_gone: res_valid seen %0d times, want 0", bad);
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        int e0;
        send_nib(4'h1);
        send_nib(4'h2);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (err !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL tmo_early: early err %0d busy=%b want 0 1", bad, busy);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || alu_a !== 8'h00) begin
            fails++;
            $display("FAIL tmo_fire: err=%b busy=%b a=%h want 1 0 00", err, busy, alu_a);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL tmo_pulse: err=%b want 0", err);
        end
        e0 = err_seen;
        send_nib(4'h3);
        send_nib(4'h4);
        repeat (7) @(negedge clk);
        send_nib(4'h5);
        send_nib(4'h6);
        send_nib(4'h0);
        wait_res();
        tests++;
        if (bus.res_data !== 8'hA8 || err_seen != e0) begin
            fails++;
            $display("FAIL tmo_edge: rd=%h errs=%0d want a8 0", bus.res_data, err_seen - e0);
        end
        handshake();
    endtask
`else
    task automatic test_no_timeout();
        send_nib(4'h1);
        send_nib(4'h2);
        repeat (20) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || alu_a !== 8'h21) begin
            fails++;
            $display("FAIL wait_stall: busy=%b a=%h want 1 21", busy, alu_a);
        end
        send_nib(4'h3);
        send_nib(4'h4);
        send_nib(4'h0);
        wait_res();
        tests++;
        if (bus.res_data !== 8'h64) begin
            fails++;
            $display("FAIL wait_result: rd=%h want 64", bus.res_data);
        end
        handshake();
        tests++;
        if (err_seen != 0) begin
            fails++;
            $display("FAIL err_tied: err high %0d cycles, want 0", err_seen);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.nib_in    = 4'h0;
        bus.nib_valid = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold_wrap();
        test_random();
        test_reset_mid();
        test_reset_hold();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
